// File: rtl/uart_fifo_xcvr_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_xcvr_if
// Brief    : Host-side bundle for uart_fifo_xcvr (TX queue push, RX results).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fifo_xcvr_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 transmit;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_full;
    logic [c_LVL_W-1:0]   tx_level;
    logic                 tx_drop;
    logic                 received;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 is_receiving;
    logic                 is_transmitting;
    logic                 recv_error;

    modport master (
        output transmit, tx_byte,
        input  tx_full, tx_level, tx_drop, received, rx_byte,
               is_receiving, is_transmitting, recv_error
    );

    modport slave (
        input  transmit, tx_byte,
        output tx_full, tx_level, tx_drop, received, rx_byte,
               is_receiving, is_transmitting, recv_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_xcvr
// Brief    : FIFO-buffered UART transceiver with internal loopback.
//            Define UART_PARITY_EN to add a parity bit (sense from PARITY_ODD).
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_xcvr #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             loopback,
    output logic             tx,
    uart_fifo_xcvr_if.slave  ctrl
);
    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_HALF  = c_CW'(CLK_DIV / 2 - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);
    localparam logic [c_LW-1:0] c_FULL_LVL  = c_LW'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd4;
    localparam logic [2:0] c_S_WAIT   = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic       c_PAR_ODD  = (PARITY_ODD != 0);
`else
    logic w_unused_parity;
    assign w_unused_parity = (PARITY_ODD != 0);
`endif

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic                 r_drop;
    logic                 w_empty, w_full, w_push, w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LVL);
    assign w_push  = ctrl.transmit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= ctrl.transmit && w_full && !w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= ctrl.tx_byte;
    end

    // ---------------- TX FSM ----------------
    logic [2:0]           r_tx_state;
    logic [c_CW-1:0]      r_tx_cnt;
    logic [c_BW-1:0]      r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_line, r_tx_busy;
    logic                 w_tx_tick, w_tx_frame_end;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    assign w_tx_tick      = (r_tx_cnt == c_CNT_LAST);
    assign w_tx_frame_end = (r_tx_state == c_S_STOP) && w_tx_tick && (r_tx_bit == c_STOP_LAST);
    // Popping at the end of STOP chains frames back-to-back with no idle gap.
    assign w_pop          = !w_empty && ((r_tx_state == c_S_IDLE) || w_tx_frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= c_S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            if (r_tx_state == c_S_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                     r_tx_cnt <= r_tx_cnt + 1'b1;

            if (w_pop) begin
                r_tx_shift <= r_mem[r_rd_ptr];
`ifdef UART_PARITY_EN
                r_tx_par   <= (^r_mem[r_rd_ptr]) ^ c_PAR_ODD;
`endif
                r_tx_state <= c_S_START;
                r_tx_line  <= 1'b0;
                r_tx_busy  <= 1'b1;
            end else begin
                case (r_tx_state)
                    c_S_START: if (w_tx_tick) begin
                        r_tx_state <= c_S_DATA;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                    end
                    c_S_DATA: if (w_tx_tick) begin
                        if (r_tx_bit == c_BIT_LAST) begin
`ifdef UART_PARITY_EN
                            r_tx_state <= c_S_PARITY;
                            r_tx_line  <= r_tx_par;
`else
                            r_tx_state <= c_S_STOP;
                            r_tx_line  <= 1'b1;
                            r_tx_bit   <= '0;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
`ifdef UART_PARITY_EN
                    c_S_PARITY: if (w_tx_tick) begin
                        r_tx_state <= c_S_STOP;
                        r_tx_line  <= 1'b1;
                        r_tx_bit   <= '0;
                    end
`endif
                    c_S_STOP: if (w_tx_tick) begin
                        if (r_tx_bit == c_STOP_LAST) begin
                            r_tx_state <= c_S_IDLE;
                            r_tx_busy  <= 1'b0;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                    default: begin
                        r_tx_state <= c_S_IDLE;
                        r_tx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx = loopback ? 1'b1 : r_tx_line;

    // ---------------- RX path ----------------
    logic                 r_sync1, r_sync2;
    logic [2:0]           r_rx_state;
    logic [c_CW-1:0]      r_rx_cnt;
    logic [c_BW-1:0]      r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_byte;
    logic                 r_received, r_recv_error, r_rx_busy;
    logic                 w_rx_src, w_line, w_rx_tick, w_par_ok;

    assign w_rx_src  = loopback ? r_tx_line : rx;
    assign w_line    = r_sync2;
    assign w_rx_tick = (r_rx_cnt == '0);
`ifdef UART_PARITY_EN
    logic r_par_err;
    assign w_par_ok = !r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rx_state   <= c_S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;
            r_rx_busy    <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_sync1      <= w_rx_src;
            r_sync2      <= r_sync1;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;
            if (r_rx_state != c_S_IDLE && r_rx_state != c_S_WAIT)
                r_rx_cnt <= w_rx_tick ? c_CNT_LAST : r_rx_cnt - 1'b1;

            case (r_rx_state)
                c_S_IDLE: if (!w_line) begin
                    r_rx_state <= c_S_START;
                    r_rx_cnt   <= c_CNT_HALF;
                    r_rx_busy  <= 1'b1;
`ifdef UART_PARITY_EN
                    r_par_err  <= 1'b0;
`endif
                end
                // Mid start bit: a high line here means a glitch, not a frame.
                c_S_START: if (w_rx_tick) begin
                    if (w_line) begin
                        r_rx_state <= c_S_IDLE;
                        r_rx_busy  <= 1'b0;
                    end else begin
                        r_rx_state <= c_S_DATA;
                        r_rx_bit   <= '0;
                    end
                end
                c_S_DATA: if (w_rx_tick) begin
                    r_rx_shift <= {w_line, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_BIT_LAST) begin
`ifdef UART_PARITY_EN
                        r_rx_state <= c_S_PARITY;
`else
                        r_rx_state <= c_S_STOP;
`endif
                    end else begin
                        r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                c_S_PARITY: if (w_rx_tick) begin
                    r_par_err  <= (w_line != ((^r_rx_shift) ^ c_PAR_ODD));
                    r_rx_state <= c_S_STOP;
                end
`endif
                c_S_STOP: if (w_rx_tick) begin
                    if (w_line && w_par_ok) begin
                        r_rx_byte  <= r_rx_shift;
                        r_received <= 1'b1;
                        r_rx_state <= c_S_IDLE;
                        r_rx_busy  <= 1'b0;
                    end else begin
                        r_recv_error <= 1'b1;
                        r_rx_state   <= c_S_WAIT;
                    end
                end
                c_S_WAIT: if (w_line) begin
                    r_rx_state <= c_S_IDLE;
                    r_rx_busy  <= 1'b0;
                end
                default: begin
                    r_rx_state <= c_S_IDLE;
                    r_rx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.tx_full         = w_full;
    assign ctrl.tx_level        = r_level;
    assign ctrl.tx_drop         = r_drop;
    assign ctrl.received        = r_received;
    assign ctrl.rx_byte         = r_rx_byte;
    assign ctrl.is_receiving    = r_rx_busy;
    assign ctrl.is_transmitting = r_tx_busy;
    assign ctrl.recv_error      = r_recv_error;
endmodule
`default_nettype wire
